video_frame_capture: RTL and testbench

- Receiving end of the raw parallel video interface that the display path drives: active-low vsync, data-enable and 8-bit greyscale pixel, all on one pixel clock.
- Measures the incoming active resolution.
- On request, captures one IMG_W x IMG_H window of a single frame into a RAM write port in row-major order.
- Sits between a timing/pixel source (test-pattern path or filter output) and a frame-buffer BRAM read back later by the loader.

---
 rtl/vfc_pkg.sv | 19 +
 rtl/vfc_if.sv | 16 +
 rtl/vfc_timing_meas.sv | 87 ++++++++
 rtl/video_frame_capture.sv | 164 ++++++++++++++++
 tb/tb_video_frame_capture.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vfc_pkg.sv
// Shared types and constants for the video frame capture block.
//   vfc_state_e : capture FSM states
//   DEF_DIM_W   : default width of coordinate/measurement counters
//   img_pixels  : pixel count of a capture window
package vfc_pkg;

    localparam int unsigned DEF_DIM_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_VS,
        ST_CAPTURE
    } vfc_state_e;

    function automatic int unsigned img_pixels(input int unsigned w, input int unsigned h);
        return w * h;
    endfunction

endpackage

// File: rtl/vfc_if.sv
// Frame-buffer RAM write port.
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : write data
// master = capture block (drives the port), slave = RAM side.
interface vfc_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 16
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (output wr_en, output wr_addr, output wr_data);
    modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/vfc_timing_meas.sv
// Sync edge detection, pixel/line coordinates and active-resolution measurement.
//   i_vs / i_de     : active-low vsync, data enable
//   o_x             : DE pixels seen so far in the current line (raw, before de_rise clear)
//   o_y             : DE lines completed since the last vsync fall
//   o_de_rise       : first DE cycle of a line
//   o_vs_fall       : frame start
//   o_h_active/o_v_active/o_timing_valid : measured resolution and its stability
module vfc_timing_meas #(
    parameter int unsigned DIM_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_vs,
    input  logic             i_de,
    output logic [DIM_W-1:0] o_x,
    output logic [DIM_W-1:0] o_y,
    output logic             o_de_rise,
    output logic             o_vs_fall,
    output logic [DIM_W-1:0] o_h_active,
    output logic [DIM_W-1:0] o_v_active,
    output logic             o_timing_valid
);
    localparam logic [DIM_W-1:0] CNT_MAX = '1;

    logic             r_vs_prev;
    logic             r_de_prev;
    logic [DIM_W-1:0] r_x;
    logic [DIM_W-1:0] r_y;
    logic [DIM_W-1:0] r_h_cur;
    logic [DIM_W-1:0] r_h_active;
    logic [DIM_W-1:0] r_v_active;
    logic             r_timing_valid;

    logic             w_vs_fall;
    logic             w_de_rise;
    logic             w_de_fall;
    logic [DIM_W-1:0] w_x;

    assign w_vs_fall = r_vs_prev & ~i_vs;
    assign w_de_rise = ~r_de_prev & i_de;
    assign w_de_fall = r_de_prev & ~i_de;
    // x of the pixel on the wire this cycle
    assign w_x       = w_de_rise ? '0 : r_x;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_prev      <= 1'b1;
            r_de_prev      <= 1'b0;
            r_x            <= '0;
            r_y            <= '0;
            r_h_cur        <= '0;
            r_h_active     <= '0;
            r_v_active     <= '0;
            r_timing_valid <= 1'b0;
        end else begin
            r_vs_prev <= i_vs;
            r_de_prev <= i_de;
            // r_x holds last x + 1, i.e. the line length once DE drops
            if (i_de) begin
                r_x <= (w_x == CNT_MAX) ? CNT_MAX : w_x + 1'b1;
            end
            if (w_de_fall) begin
                r_h_cur <= r_x;
            end
            if (w_vs_fall) begin
                r_y <= '0;
                // a frame without DE lines carries no measurement
                if (r_y != '0) begin
                    r_h_active     <= r_h_cur;
                    r_v_active     <= r_y;
                    r_timing_valid <= (r_h_cur == r_h_active) && (r_y == r_v_active);
                end
            end else if (w_de_fall && (r_y != CNT_MAX)) begin
                r_y <= r_y + 1'b1;
            end
        end
    end

    assign o_x            = r_x;
    assign o_y            = r_y;
    assign o_de_rise      = w_de_rise;
    assign o_vs_fall      = w_vs_fall;
    assign o_h_active     = r_h_active;
    assign o_v_active     = r_v_active;
    assign o_timing_valid = r_timing_valid;

endmodule

// File: rtl/video_frame_capture.sv
// Captures one IMG_W x IMG_H window of a frame into a RAM write port, row-major,
// and reports the measured active resolution of the incoming video.
//   clk, rst_n        : pixel clock, async active-low reset
//   i_vs/i_de/i_data  : raw parallel video in
//   i_arm             : capture request (ignored while busy)
//   o_busy/o_done/o_short : capture status; o_short flags a frame that ended early
//   o_wr              : RAM write port (master side)
//   o_h_active/o_v_active/o_timing_valid : measured resolution
module video_frame_capture
    import vfc_pkg::*;
#(
    parameter int unsigned IMG_W   = 225,
    parameter int unsigned IMG_H   = 225,
    parameter int unsigned START_X = 0,
    parameter int unsigned START_Y = 0,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DIM_W   = DEF_DIM_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_vs,
    input  logic              i_de,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_arm,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_short,
    vfc_if.master             o_wr,
    output logic [DIM_W-1:0]  o_h_active,
    output logic [DIM_W-1:0]  o_v_active,
    output logic              o_timing_valid
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(img_pixels(IMG_W, IMG_H) - 1);

    logic [DIM_W-1:0] w_x;
    logic [DIM_W-1:0] w_y;
    logic [DIM_W-1:0] w_cur_x;
    logic             w_de_rise;
    logic             w_vs_fall;
    logic             w_x_ge;
    logic             w_x_lt;
    logic             w_y_ge;
    logic             w_y_lt;
    logic             w_in_win;

    vfc_timing_meas #(
        .DIM_W (DIM_W)
    ) u_meas (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_vs           (i_vs),
        .i_de           (i_de),
        .o_x            (w_x),
        .o_y            (w_y),
        .o_de_rise      (w_de_rise),
        .o_vs_fall      (w_vs_fall),
        .o_h_active     (o_h_active),
        .o_v_active     (o_v_active),
        .o_timing_valid (o_timing_valid)
    );

    assign w_cur_x = w_de_rise ? '0 : w_x;

    // Lower bounds of zero would be constant-true compares
    if (START_X == 0) begin : g_x_lo_zero
        assign w_x_ge = 1'b1;
    end else begin : g_x_lo
        assign w_x_ge = ({1'b0, w_cur_x} >= (DIM_W+1)'(START_X));
    end
    if (START_Y == 0) begin : g_y_lo_zero
        assign w_y_ge = 1'b1;
    end else begin : g_y_lo
        assign w_y_ge = ({1'b0, w_y} >= (DIM_W+1)'(START_Y));
    end
    assign w_x_lt   = ({1'b0, w_cur_x} < (DIM_W+1)'(START_X + IMG_W));
    assign w_y_lt   = ({1'b0, w_y} < (DIM_W+1)'(START_Y + IMG_H));
    assign w_in_win = i_de & w_x_ge & w_x_lt & w_y_ge & w_y_lt;

    vfc_state_e        r_state;
    vfc_state_e        w_state_d;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_wr_en;
    logic              r_done;
    logic              r_short;
    logic              w_cap;
    logic              w_clr_addr;
    logic              w_done_d;
    logic              w_short_d;
    logic              w_last_wr;

    assign w_last_wr = r_wr_en && (r_wr_addr == LAST_ADDR);

    always_comb begin
        w_state_d  = r_state;
        w_cap      = 1'b0;
        w_clr_addr = 1'b0;
        w_done_d   = 1'b0;
        w_short_d  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_arm) begin
                    w_state_d = ST_WAIT_VS;
                end
            end
            ST_WAIT_VS: begin
                if (w_vs_fall) begin
                    w_state_d  = ST_CAPTURE;
                    w_clr_addr = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (w_last_wr) begin
                    // success wins over a vsync fall in the same cycle
                    w_state_d = ST_IDLE;
                    w_done_d  = 1'b1;
                end else if (w_vs_fall && !(w_in_win && (r_addr == LAST_ADDR))) begin
                    w_state_d = ST_IDLE;
                    w_done_d  = 1'b1;
                    w_short_d = 1'b1;
                end else begin
                    w_cap = w_in_win;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_wr_en   <= 1'b0;
            r_done    <= 1'b0;
            r_short   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_wr_en <= w_cap;
            r_done  <= w_done_d;
            r_short <= w_short_d;
            if (w_cap) begin
                r_wr_addr <= r_addr;
                r_wr_data <= i_data;
            end
            if (w_clr_addr) begin
                r_addr <= '0;
            end else if (w_cap) begin
                r_addr <= r_addr + 1'b1;
            end
        end
    end

    assign o_busy        = (r_state != ST_IDLE);
    assign o_done        = r_done;
    assign o_short       = r_short;
    assign o_wr.wr_en    = r_wr_en;
    assign o_wr.wr_addr  = r_wr_addr;
    assign o_wr.wr_data  = r_wr_data;

endmodule

// File: tb/tb_video_frame_capture.sv
// Two captures share one video source: A grabs a 32x24 window at the origin,
// B a 4x4 window at (10,5). Frames are 48x36 active (60x42 total) unless noted.
module tb_video_frame_capture;

    localparam int AW = 32, AH = 24, BW = 4, BH = 4, BSX = 10, BSY = 5;

    logic        clk = 1'b0;
    logic        rst_n, vs, de, arm_a, arm_b;
    logic [7:0]  data;
    logic        busy_a, done_a, short_a, tv_a, busy_b, done_b, short_b, tv_b;
    logic [11:0] h_a, v_a, h_b, v_b;

    always #5 clk = ~clk;

    vfc_if #(.DATA_W(8), .ADDR_W(16)) wr_a ();
    vfc_if #(.DATA_W(8), .ADDR_W(16)) wr_b ();

    video_frame_capture #(
        .IMG_W(AW), .IMG_H(AH), .START_X(0), .START_Y(0), .DATA_W(8), .ADDR_W(16), .DIM_W(12)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .i_vs(vs), .i_de(de), .i_data(data), .i_arm(arm_a),
        .o_busy(busy_a), .o_done(done_a), .o_short(short_a), .o_wr(wr_a),
        .o_h_active(h_a), .o_v_active(v_a), .o_timing_valid(tv_a)
    );

    video_frame_capture #(
        .IMG_W(BW), .IMG_H(BH), .START_X(BSX), .START_Y(BSY), .DATA_W(8), .ADDR_W(16),
        .DIM_W(12)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .i_vs(vs), .i_de(de), .i_data(data), .i_arm(arm_b),
        .o_busy(busy_b), .o_done(done_b), .o_short(short_b), .o_wr(wr_b),
        .o_h_active(h_b), .o_v_active(v_b), .o_timing_valid(tv_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: capture windows, progress and expectations per DUT
    int   m_w [2], m_h [2], m_sx [2], m_sy [2];
    bit   m_pend [2], m_cap [2], m_busy [2], m_last [2];
    int   m_cnt [2];
    bit   e_wr [2], e_done [2], e_short [2];
    int   e_addr [2];
    logic [7:0] e_data [2];

    int   wr_cnt [2], done_cnt [2], short_cnt [2];
    logic [7:0] ram_a [0:1023];
    logic [7:0] ram_b [0:15];
    logic [7:0] pix [0:63][0:63];
    logic vs_in_prev;
    int   rst_cycles;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_a_wr_en"}, 32'(wr_a.wr_en), 0);
        chk({tag, "_a_busy"},  32'(busy_a), 0);
        chk({tag, "_a_done"},  32'(done_a), 0);
        chk({tag, "_a_short"}, 32'(short_a), 0);
        chk({tag, "_a_h"},     32'(h_a), 0);
        chk({tag, "_a_v"},     32'(v_a), 0);
        chk({tag, "_a_tv"},    32'(tv_a), 0);
        chk({tag, "_b_wr_en"}, 32'(wr_b.wr_en), 0);
        chk({tag, "_b_busy"},  32'(busy_b), 0);
        chk({tag, "_b_h"},     32'(h_b), 0);
        chk({tag, "_b_tv"},    32'(tv_b), 0);
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            m_pend[k] = 0; m_cap[k] = 0; m_busy[k] = 0; m_last[k] = 0; m_cnt[k] = 0;
            e_wr[k] = 0; e_done[k] = 0; e_short[k] = 0; e_addr[k] = 0; e_data[k] = '0;
        end
    endtask

    task automatic meas(input string tag, input int h, input int v, input int tv);
        chk({tag, "_h_a"}, 32'(h_a), h);
        chk({tag, "_v_a"}, 32'(v_a), v);
        chk({tag, "_tv_a"}, 32'(tv_a), tv);
        chk({tag, "_h_b"}, 32'(h_b), h);
        chk({tag, "_v_b"}, 32'(v_b), v);
    endtask

    // One pixel clock: drive inputs, predict, clock, compare.
    task automatic cyc(input logic vs_v, input logic de_v, input logic [7:0] d,
                       input int x, input int y, input logic a0, input logic a1);
        logic   fall, armk, was_busy, win;
        string  p;
        logic   o_en, o_dn, o_sh, o_bz;
        logic [15:0] o_ad;
        logic [7:0]  o_dt;
        fall = vs_in_prev & ~vs_v;
        vs_in_prev = vs_v;
        vs = vs_v; de = de_v; data = d; arm_a = a0; arm_b = a1;
        if (rst_cycles > 0) begin
            model_clear();
        end else begin
            for (int k = 0; k < 2; k++) begin
                was_busy = m_busy[k];
                e_wr[k] = 0; e_done[k] = 0; e_short[k] = 0;
                if (m_last[k]) begin
                    m_last[k] = 0; m_cap[k] = 0; m_busy[k] = 0; e_done[k] = 1;
                end else if (m_cap[k]) begin
                    win = de_v && x >= m_sx[k] && x < m_sx[k] + m_w[k]
                          && y >= m_sy[k] && y < m_sy[k] + m_h[k];
                    if (win) begin
                        e_wr[k] = 1; e_addr[k] = m_cnt[k]; e_data[k] = d;
                        if (m_cnt[k] == m_w[k] * m_h[k] - 1) m_last[k] = 1;
                        m_cnt[k]++;
                    end else if (fall) begin
                        m_cap[k] = 0; m_busy[k] = 0; e_done[k] = 1; e_short[k] = 1;
                    end
                end else if (m_pend[k] && fall) begin
                    m_pend[k] = 0; m_cap[k] = 1; m_cnt[k] = 0;
                end
                armk = (k == 0) ? a0 : a1;
                if (armk && !was_busy) begin
                    m_busy[k] = 1; m_pend[k] = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        if (rst_cycles > 0) begin
            rst_cycles--;
            if (rst_cycles == 0) rst_n = 1'b1;
        end
        for (int k = 0; k < 2; k++) begin
            p    = (k == 0) ? "a" : "b";
            o_en = (k == 0) ? wr_a.wr_en : wr_b.wr_en;
            o_ad = (k == 0) ? wr_a.wr_addr : wr_b.wr_addr;
            o_dt = (k == 0) ? wr_a.wr_data : wr_b.wr_data;
            o_dn = (k == 0) ? done_a : done_b;
            o_sh = (k == 0) ? short_a : short_b;
            o_bz = (k == 0) ? busy_a : busy_b;
            chk({p, "_wr_en"}, 32'(o_en), 32'(e_wr[k]));
            if (e_wr[k]) begin
                chk({p, "_wr_addr"}, 32'(o_ad), e_addr[k]);
                chk({p, "_wr_data"}, 32'(o_dt), 32'(e_data[k]));
            end
            chk({p, "_done"},  32'(o_dn), 32'(e_done[k]));
            chk({p, "_short"}, 32'(o_sh), 32'(e_short[k]));
            chk({p, "_busy"},  32'(o_bz), 32'(m_busy[k]));
            if (o_en === 1'b1) begin
                wr_cnt[k]++;
                if (k == 0 && o_ad < 1024) ram_a[o_ad[9:0]] = o_dt;
                if (k == 1 && o_ad < 16) ram_b[o_ad[3:0]] = o_dt;
            end
            if (o_dn === 1'b1) done_cnt[k]++;
            if (o_sh === 1'b1) short_cnt[k]++;
        end
    endtask

    // One frame: active lines first, vsync low on lines va+2..va+3.
    task automatic run_frame(input int ha, input int va, input int aal, input int aac,
                             input int abl, input int abc, input int rl, input int rc);
        logic [7:0] d;
        for (int l = 0; l < va + 6; l++) begin
            for (int c = 0; c < ha + 12; c++) begin
                d = 8'($urandom);
                if (l < va && c < ha) pix[l][c] = d;
                if (l == rl && c == rc) begin
                    rst_n = 1'b0;
                    #1;
                    chk_zero("rst_async");
                    rst_cycles = 3;
                end
                cyc(!(l == va + 2 || l == va + 3), (l < va && c < ha), d, c, l,
                    (l == aal && c == aac), (l == abl && c == abc));
            end
        end
    endtask

    task automatic clr_counts();
        for (int k = 0; k < 2; k++) begin
            wr_cnt[k] = 0; done_cnt[k] = 0; short_cnt[k] = 0;
        end
    endtask

    initial begin
        m_w[0] = AW; m_h[0] = AH; m_sx[0] = 0;   m_sy[0] = 0;
        m_w[1] = BW; m_h[1] = BH; m_sx[1] = BSX; m_sy[1] = BSY;
        model_clear();
        clr_counts();
        rst_cycles = 0;
        vs_in_prev = 1'b1;
        rst_n = 1'b0; vs = 1'b1; de = 1'b0; data = '0; arm_a = 1'b0; arm_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;

        // Frame 0 arms both; measurement after the first vsync fall
        run_frame(48, 36, $urandom_range(0, 30), $urandom_range(0, 59),
                  $urandom_range(0, 30), $urandom_range(0, 59), -1, -1);
        meas("f0", 48, 36, 0);
        clr_counts();

        // Frame 1 is captured; an extra arm mid-capture must be ignored
        run_frame(48, 36, 10, 3, -1, -1, -1, -1);
        meas("f1", 48, 36, 1);
        chk("f1_a_writes", wr_cnt[0], AW * AH);
        chk("f1_b_writes", wr_cnt[1], BW * BH);
        chk("f1_a_done_cnt", done_cnt[0], 1);
        chk("f1_a_short_cnt", short_cnt[0], 0);
        chk("f1_a_first", 32'(ram_a[0]), 32'(pix[0][0]));
        chk("f1_a_last", 32'(ram_a[AW * AH - 1]), 32'(pix[AH - 1][AW - 1]));
        chk("f1_b_first", 32'(ram_b[0]), 32'(pix[BSY][BSX]));
        chk("f1_b_last", 32'(ram_b[15]), 32'(pix[BSY + 3][BSX + 3]));

        // Source smaller than window A: capture ends by abort
        run_frame(20, 16, 2, 0, -1, -1, -1, -1);
        meas("f2", 20, 16, 0);
        clr_counts();
        run_frame(20, 16, -1, -1, -1, -1, -1, -1);
        meas("f3", 20, 16, 1);
        chk("f3_a_writes", wr_cnt[0], 20 * 16);
        chk("f3_a_short_cnt", short_cnt[0], 1);
        chk("f3_a_done_cnt", done_cnt[0], 1);

        // Reset in the middle of capture (line 3, column 5)
        run_frame(48, 36, 2, 0, -1, -1, -1, -1);
        meas("f4", 48, 36, 0);
        clr_counts();
        run_frame(48, 36, -1, -1, -1, -1, 3, 5);
        chk("f5_a_writes", wr_cnt[0], 3 * AW + 5);
        meas("f5", 48, 33, 0);
        run_frame(48, 36, 2, 0, -1, -1, -1, -1);
        meas("f6", 48, 36, 0);
        clr_counts();
        run_frame(48, 36, -1, -1, -1, -1, -1, -1);
        meas("f7", 48, 36, 1);
        chk("f7_a_writes", wr_cnt[0], AW * AH);
        chk("f7_a_last", 32'(ram_a[AW * AH - 1]), 32'(pix[AH - 1][AW - 1]));

        // Frame with no DE lines; B armed on the vsync-fall cycle itself
        run_frame(48, 0, -1, -1, 2, 0, -1, -1);
        meas("f8", 48, 36, 1);
        clr_counts();
        run_frame(48, 36, -1, -1, -1, -1, -1, -1);
        chk("f9_b_writes", wr_cnt[1], 0);
        run_frame(48, 36, -1, -1, -1, -1, -1, -1);
        chk("f10_b_writes", wr_cnt[1], BW * BH);
        chk("f10_b_first", 32'(ram_b[0]), 32'(pix[BSY][BSX]));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
